spi_slave_pwm_multi: RTL and testbench
======================================

Name: spi_slave_pwm_multi

Overview:
SPI-controlled multi-channel PWM generator, the next generation of the single-channel SPI slave PWM bot. SPI pins are sampled in the system clock domain, not on SCLK. Each frame carries a channel address plus a duty value and lands in a per-channel shadow register. Shadows load into active duty registers only at the PWM period boundary, so outputs stay glitch-free; MISO echoes the previous frame.

Parameters:
CPOL, 1, SCLK idle level
CPHA, 1, 0 = sample on first SCLK edge, 1 = sample on second edge
PACK_LENGTH, 8, duty field width in bits
CHANNELS, 4, number of PWM outputs (1..15)
ADDR_WIDTH, 4, address field width; must satisfy 2**ADDR_WIDTH > CHANNELS
MSB_FIRST, 1, 1 = major bit forward on MOSI and MISO; 0 = junior bit forward
MAX_VALUE, 2**PACK_LENGTH-1, PWM period in ticks
PRESCALE, 1, IN_CLOCK cycles per PWM tick (>=1)
FRAME_BITS, ADDR_WIDTH+PACK_LENGTH, derived; address field is transmitted first

Ports:
IN_CLOCK  in  1  system clock
IN_RESET  in  1  synchronous, active-low reset
SCLK  in  1  SPI clock, asynchronous to IN_CLOCK
MOSI  in  1  SPI data in
CS  in  1  chip select, active-low
MISO  out  1  SPI data out
OUT_PWM_SIGNAL  out  CHANNELS  PWM outputs
OUT_FRAME_VALID  out  1  one-cycle pulse when a frame is accepted
OUT_FRAME_ERROR  out  1  one-cycle pulse when a frame is rejected

Behaviour:
- Reset (IN_RESET=0 at an IN_CLOCK edge):
  - shadow and active duties = 0
  - PWM counter and prescaler = 0
  - OUT_PWM_SIGNAL = 0
  - MISO = 0, both pulse outputs = 0
  - bit counter = 0, echo register = 0
  - any frame in progress is discarded
- Input sync:
  - SCLK, MOSI and CS each pass through a 2-FF synchroniser; a 3rd flop is used for edge detect.
  - Supported SCLK frequency is <= IN_CLOCK/8.
- SPI FSM states: IDLE, SHIFT, COMMIT.
  - IDLE -> SHIFT on synchronised CS falling edge; clears bit counter and loads the echo register into the TX shift register.
  - SHIFT, sample edge: shift MOSI into the RX register (position per MSB_FIRST); bit counter saturates at FRAME_BITS+1.
  - SHIFT, drive edge: present the next TX bit on MISO.
  - Sample edge is the leading edge when CPHA=0, the trailing edge when CPHA=1. Leading edge is rising when CPOL=0, falling when CPOL=1.
  - For CPHA=0, the first TX bit is on MISO within 1 IN_CLOCK cycle of CS falling edge detection.
  - SHIFT -> COMMIT on synchronised CS rising edge.
  - COMMIT lasts one cycle, then -> IDLE. MISO is 0 whenever the FSM is in IDLE.
- Commit rules:
  - Bit count must equal FRAME_BITS exactly, else error.
  - addr < CHANNELS: write shadow[addr] = duty.
  - addr = 2**ADDR_WIDTH-1 (broadcast): write all shadows.
  - Any other address is an error.
  - Accept: OUT_FRAME_VALID pulses in the COMMIT cycle and the echo register takes the full RX frame.
  - Error: OUT_FRAME_ERROR pulses in the COMMIT cycle; no shadow is written and the echo register is unchanged.
- PWM:
  - Prescaler counts 0..PRESCALE-1; each wrap produces one tick.
  - Counter counts 0..MAX_VALUE-1 on ticks.
  - In the IN_CLOCK cycle where the counter wraps to 0, every active duty loads from its shadow.
  - If a commit and a wrap occur in the same cycle, the new shadow value is captured into active in that same cycle (write-through).
  - OUT_PWM_SIGNAL[i] is registered: 1 when counter < active[i].
  - duty 0 gives constant 0; duty >= MAX_VALUE gives constant 1.
  - Latency from counter change to output change: 1 IN_CLOCK cycle.
- Reset mid-frame: the FSM forces IDLE; SCLK edges are ignored until a new CS falling edge.

Decomposition:
- Package spi_pwm_pkg holds:
  - FSM state enum (IDLE, SHIFT, COMMIT)
  - broadcast address constant function
  - frame field slice helpers
- One natural sub-module: spi_pwm_channel. It holds one channel's shadow/active register pair plus its comparator, instantiated CHANNELS times.
- The shared counter/prescaler and the SPI FSM stay in the top.

Test Plan:
1. Reset, no SPI traffic -> all OUT_PWM_SIGNAL = 0, MISO = 0, no pulses for 2 PWM periods.
2. CPOL=1, CPHA=1, frame addr=2, duty=0x40 -> OUT_FRAME_VALID pulses. Channel 2 is high for exactly 64 of 255 ticks starting at the next wrap; other channels stay 0.
3. Broadcast frame addr=0xF, duty=0xFF -> all channels constant 1 from the next period. A second frame then returns 0xFFF on MISO.
4. Short frame of 11 bits, and a separate frame with addr=5 (>= CHANNELS) -> OUT_FRAME_ERROR pulses, duties unchanged, echo unchanged.
5. Commit timed to land in the counter-wrap cycle with duty=0x10 -> new duty is active in that period; no runt or extended pulse on the previous period.
6. IN_RESET asserted after 6 bits of a frame, then a complete frame addr=0, duty=0x80 -> only the second frame is applied; channel 0 runs at a 128/255 high fraction.

Source files
------------

// File: rtl/spi_pwm_pkg.sv
// spi_pwm_pkg: shared FSM states, broadcast address and frame field helpers for the SPI PWM block
package spi_pwm_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} spi_state_e;
  function automatic logic [31:0] bcast_addr(input int aw);
    return (32'd1 << aw) - 32'd1;
  endfunction
  function automatic logic [31:0] frame_addr(input logic [31:0] f, input int aw, input int pw, input logic msb_first);
    return (msb_first ? f >> pw : f) & bcast_addr(aw);
  endfunction
  function automatic logic [31:0] frame_duty(input logic [31:0] f, input int aw, input int pw, input logic msb_first);
    return (msb_first ? f : f >> aw) & ((32'd1 << pw) - 32'd1);
  endfunction
endpackage

// File: rtl/spi_pwm_channel.sv
// spi_pwm_channel: one PWM channel with shadow/active duty pair and registered comparator
module spi_pwm_channel #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_data,
  input  logic          load,
  input  logic [PW-1:0] cnt,
  output logic          pwm
);
  logic [PW-1:0] shadow_q, shadow_d, active_q, active_d;
  logic pwm_q, pwm_d;
  always_comb begin
    shadow_d = wr_en ? wr_data : shadow_q;
    active_d = load ? shadow_d : active_q;
    pwm_d = cnt < active_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q <= pwm_d;
    end
  assign pwm = pwm_q;
endmodule

// File: rtl/spi_slave_pwm_multi.sv
// spi_slave_pwm_multi: oversampled SPI slave writing per-channel PWM duties that apply at period boundaries
module spi_slave_pwm_multi
  import spi_pwm_pkg::*;
#(
  parameter int CPOL        = 1,
  parameter int CPHA        = 1,
  parameter int PACK_LENGTH = 8,
  parameter int CHANNELS    = 4,
  parameter int ADDR_WIDTH  = 4,
  parameter int MSB_FIRST   = 1,
  parameter int MAX_VALUE   = 2**PACK_LENGTH-1,
  parameter int PRESCALE    = 1
) (
  input  logic                IN_CLOCK,
  input  logic                IN_RESET,
  input  logic                SCLK,
  input  logic                MOSI,
  input  logic                CS,
  output logic                MISO,
  output logic [CHANNELS-1:0] OUT_PWM_SIGNAL,
  output logic                OUT_FRAME_VALID,
  output logic                OUT_FRAME_ERROR
);
  localparam int FRAME_BITS = ADDR_WIDTH + PACK_LENGTH;
  localparam int BW = $clog2(FRAME_BITS + 2);
  localparam int PSW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [2:0] SCLK_RST = CPOL != 0 ? 3'b111 : 3'b000;
  localparam logic [BW-1:0] BITS_FULL = BW'(FRAME_BITS);
  localparam logic [BW-1:0] BITS_SAT = BW'(FRAME_BITS + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_BCAST = ADDR_WIDTH'(bcast_addr(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIM = ADDR_WIDTH'(CHANNELS);
  function automatic logic [FRAME_BITS-1:0] shl(input logic [FRAME_BITS-1:0] v, input logic b);
    return MSB_FIRST != 0 ? {v[FRAME_BITS-2:0], b} : {b, v[FRAME_BITS-1:1]};
  endfunction
  function automatic logic head(input logic [FRAME_BITS-1:0] v);
    return MSB_FIRST != 0 ? v[FRAME_BITS-1] : v[0];
  endfunction
  logic [2:0] sclk_q, sclk_d, cs_q, cs_d;
  logic [1:0] mosi_q, mosi_d;
  spi_state_e state_q, state_d;
  logic [BW-1:0] bits_q, bits_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d, tx_q, tx_d, echo_q, echo_d;
  logic miso_q, miso_d;
  logic [PSW-1:0] presc_q, presc_d;
  logic [PACK_LENGTH-1:0] cnt_q, cnt_d, duty;
  logic [ADDR_WIDTH-1:0] addr;
  logic lead, trail, sample, drive, cs_fall, cs_rise, commit, ok, tick, wrap;
  always_comb begin
    sclk_d = {sclk_q[1:0], SCLK};
    cs_d = {cs_q[1:0], CS};
    mosi_d = {mosi_q[0], MOSI};
    lead = CPOL != 0 ? sclk_q[2] & ~sclk_q[1] : ~sclk_q[2] & sclk_q[1];
    trail = CPOL != 0 ? ~sclk_q[2] & sclk_q[1] : sclk_q[2] & ~sclk_q[1];
    sample = CPHA != 0 ? trail : lead;
    drive = CPHA != 0 ? lead : trail;
    cs_fall = cs_q[2] & ~cs_q[1];
    cs_rise = ~cs_q[2] & cs_q[1];
    addr = ADDR_WIDTH'(frame_addr(32'(rx_q), ADDR_WIDTH, PACK_LENGTH, MSB_FIRST != 0));
    duty = PACK_LENGTH'(frame_duty(32'(rx_q), ADDR_WIDTH, PACK_LENGTH, MSB_FIRST != 0));
    commit = state_q == ST_COMMIT;
    ok = bits_q == BITS_FULL && (addr < ADDR_LIM || addr == ADDR_BCAST);
    state_d = state_q;
    bits_d = bits_q;
    rx_d = rx_q;
    tx_d = tx_q;
    miso_d = miso_q;
    echo_d = echo_q;
    if (state_q == ST_IDLE) begin
      if (cs_fall) begin
        state_d = ST_SHIFT;
        bits_d = '0;
        tx_d = CPHA != 0 ? echo_q : shl(echo_q, 1'b0);
        miso_d = CPHA != 0 ? 1'b0 : head(echo_q);
      end
    end else if (state_q == ST_SHIFT) begin
      if (sample) begin
        rx_d = shl(rx_q, mosi_q[1]);
        bits_d = bits_q == BITS_SAT ? bits_q : bits_q + BW'(1);
      end
      if (drive) begin
        miso_d = head(tx_q);
        tx_d = shl(tx_q, 1'b0);
      end
      if (cs_rise) state_d = ST_COMMIT;
    end else begin
      state_d = ST_IDLE;
      miso_d = 1'b0;
      echo_d = ok ? rx_q : echo_q;
    end
    tick = presc_q == PSW'(PRESCALE - 1);
    wrap = tick && cnt_q == PACK_LENGTH'(MAX_VALUE - 1);
    presc_d = tick ? '0 : presc_q + PSW'(1);
    cnt_d = wrap ? '0 : tick ? cnt_q + PACK_LENGTH'(1) : cnt_q;
  end
  always_ff @(posedge IN_CLOCK)
    if (!IN_RESET) begin
      sclk_q <= SCLK_RST;
      cs_q <= '0;
      mosi_q <= '0;
      state_q <= ST_IDLE;
      bits_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      echo_q <= '0;
      miso_q <= 1'b0;
      presc_q <= '0;
      cnt_q <= '0;
    end else begin
      sclk_q <= sclk_d;
      cs_q <= cs_d;
      mosi_q <= mosi_d;
      state_q <= state_d;
      bits_q <= bits_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      echo_q <= echo_d;
      miso_q <= miso_d;
      presc_q <= presc_d;
      cnt_q <= cnt_d;
    end
  assign MISO = miso_q & (state_q != ST_IDLE);
  assign OUT_FRAME_VALID = commit & ok;
  assign OUT_FRAME_ERROR = commit & ~ok;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    spi_pwm_channel #(.PW(PACK_LENGTH)) u_ch (
      .clk(IN_CLOCK),
      .rst_n(IN_RESET),
      .wr_en(OUT_FRAME_VALID & (addr == ADDR_BCAST || addr == ADDR_WIDTH'(i))),
      .wr_data(duty),
      .load(wrap),
      .cnt(cnt_q),
      .pwm(OUT_PWM_SIGNAL[i])
    );
  end
endmodule

// File: tb/tb_spi_slave_pwm_multi.sv
// tb_spi_slave_pwm_multi: directed and random SPI frames checked against a per-period duty model
module tb_spi_slave_pwm_multi;
  localparam int NCH = 4;
  localparam int PER = 510;
  localparam int HALF = 5;
  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b1, mosi = 1'b0, cs = 1'b1;
  logic miso, vld, err;
  logic [NCH-1:0] pwm;
  int checks = 0, errors = 0;
  int mcyc = 0;
  int n_vld = 0, n_err = 0, miso_hi = 0;
  int acc [NCH];
  int per_hi [64][NCH];
  logic [7:0] shadow_m [NCH];
  logic [11:0] echo_m;
  always #5 clk = ~clk;
  spi_slave_pwm_multi #(.PRESCALE(2)) dut (
    .IN_CLOCK(clk),
    .IN_RESET(rst_n),
    .SCLK(sclk),
    .MOSI(mosi),
    .CS(cs),
    .MISO(miso),
    .OUT_PWM_SIGNAL(pwm),
    .OUT_FRAME_VALID(vld),
    .OUT_FRAME_ERROR(err)
  );
  always @(posedge clk) mcyc <= rst_n ? mcyc + 1 : 0;
  always @(negedge clk) begin
    n_vld += int'(vld);
    n_err += int'(err);
    miso_hi += int'(miso);
    for (int c = 0; c < NCH; c++) begin
      acc[c] = (mcyc % PER == 1) ? int'(pwm[c]) : acc[c] + int'(pwm[c]);
      if (mcyc % PER == 0 && mcyc > 0 && mcyc / PER <= 64) per_hi[mcyc / PER - 1][c] = acc[c];
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_mcyc(input int target);
    for (int i = 0; i < 40000 && mcyc < target; i++) @(negedge clk);
    #1;
  endtask
  task automatic spi_frame(input int nb, input logic [12:0] d, input logic raise, output logic [12:0] rxd);
    rxd = '0;
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int b = nb - 1; b >= 0; b--) begin
      sclk = 1'b0;
      mosi = d[b];
      repeat (HALF) @(negedge clk);
      rxd = {rxd[11:0], miso};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    if (raise) begin
      cs = 1'b1;
      repeat (2 * HALF) @(negedge clk);
    end
  endtask
  task automatic model_commit(input int nb, input logic [12:0] d, output logic ok);
    logic [3:0] a;
    a = d[11:8];
    ok = nb == 12 && (a < 4'd4 || a == 4'hF);
    if (ok) begin
      echo_m = d[11:0];
      for (int c = 0; c < NCH; c++) if (a == 4'hF || a == 4'(c)) shadow_m[c] = d[7:0];
    end
  endtask
  task automatic do_frame(input string tag, input int nb, input logic [12:0] d);
    logic [12:0] rxd;
    logic [11:0] old_echo;
    logic ok;
    int v0, e0;
    v0 = n_vld;
    e0 = n_err;
    old_echo = echo_m;
    spi_frame(nb, d, 1'b1, rxd);
    model_commit(nb, d, ok);
    if (nb <= 12) check({tag, "_miso"}, 32'(rxd), 32'(old_echo >> (12 - nb)));
    check({tag, "_valid"}, n_vld - v0, 32'(ok));
    check({tag, "_error"}, n_err - e0, 32'(!ok));
  endtask
  task automatic check_duties(input string tag);
    int p;
    p = (mcyc - 1) / PER;
    wait_mcyc(PER * (p + 2) + 1);
    for (int c = 0; c < NCH; c++) check($sformatf("%s_ch%0d", tag, c), per_hi[p + 1][c], 2 * int'(shadow_m[c]));
  endtask
  task automatic model_reset();
    for (int c = 0; c < NCH; c++) shadow_m[c] = 8'h00;
    echo_m = 12'h000;
  endtask
  initial begin
    logic [12:0] rxd, d;
    logic ok;
    int v0, e0, m0, q, nb;
    logic [7:0] old3;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(pwm), 0);
    check("rst_miso", 32'(miso), 0);
    check("rst_pulses", {30'd0, vld, err}, 0);
    rst_n = 1'b1;
    v0 = n_vld; e0 = n_err; m0 = miso_hi;
    wait_mcyc(2 * PER + 1);
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < NCH; c++) check($sformatf("idle_p%0d_ch%0d", p, c), per_hi[p][c], 0);
    check("idle_pulses", (n_vld - v0) + (n_err - e0), 0);
    check("idle_miso", miso_hi - m0, 0);
    do_frame("t2", 12, 13'h240);
    check_duties("t2");
    do_frame("t3a", 12, 13'hFFF);
    check_duties("t3a");
    do_frame("t3b", 12, 13'h1AA);
    check_duties("t3b");
    do_frame("t4_short", 11, 13'h3C5);
    do_frame("t4_addr5", 12, 13'h533);
    do_frame("t4_echo", 12, 13'h05A);
    check_duties("t4");
    for (int k = 0; k < 8; k++) begin
      nb = 11 + int'($urandom_range(0, 3));
      nb = nb > 13 ? 12 : nb;
      d = 13'($urandom);
      if ($urandom_range(0, 2) == 0) d[11:8] = 4'hF;
      do_frame($sformatf("rnd%0d", k), nb, d);
    end
    check_duties("rnd");
    do_frame("t5_pre", 12, 13'h330);
    check_duties("t5_pre");
    old3 = shadow_m[3];
    for (int i = 0; i < 2 * PER && mcyc % PER != 300; i++) @(negedge clk);
    q = mcyc / PER;
    v0 = n_vld;
    spi_frame(12, 13'h310, 1'b0, rxd);
    for (int i = 0; i < 2 * PER && mcyc % PER != 506; i++) @(negedge clk);
    cs = 1'b1;
    model_commit(12, 13'h310, ok);
    wait_mcyc(PER * (q + 2) + 1);
    check("t5_valid", n_vld - v0, 32'(ok));
    check("t5_prev_period", per_hi[q][3], 2 * int'(old3));
    check("t5_wrap_period", per_hi[q + 1][3], 2 * int'(shadow_m[3]));
    for (int c = 0; c < 3; c++) check($sformatf("t5_other_ch%0d", c), per_hi[q + 1][c], 2 * int'(shadow_m[c]));
    spi_frame(6, 13'h123, 1'b0, rxd);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_rst_pwm", 32'(pwm), 0);
    check("t6_rst_miso", 32'(miso), 0);
    model_reset();
    rst_n = 1'b1;
    v0 = n_vld; e0 = n_err;
    repeat (2) begin
      sclk = 1'b0;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    check("t6_stray_pulses", (n_vld - v0) + (n_err - e0), 0);
    do_frame("t6", 12, 13'h080);
    check_duties("t6");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
